// File: rtl/crossbar.sv
// ---------------------------------------------------------------------------
// crossbar
//
// N-input, M-output self-routing packet switch. Every input has its own FIFO.
// The head word of each FIFO carries its destination in
// word[ROUTE_LSB +: OUT_ADDR_WIDTH]. Each output runs a round-robin arbiter
// over the inputs whose head word targets it. Words leave through a
// registered output stage.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   in_valid[i]  word present on input i
//   in_data      input i at [(IN_PORTS-1-i)*WIDTH +: WIDTH]
//   full[i]      FIFO i holds FIFO_DEPTH words; writes are dropped
//   almost_full  FIFO i holds at least FIFO_DEPTH-AF_MARGIN words
//   out_valid[o] one-cycle pulse, word present on output o
//   out_data     output o at [(OUT_PORTS-1-o)*WIDTH +: WIDTH]; holds when idle
//   stall[o]     downstream o cannot accept; output o grants nothing
//
// Optional build macro
//   CROSSBAR_OVERFLOW_CHECK_EN  simulation-only messages for dropped writes
//                               and discarded bad-route words
// ---------------------------------------------------------------------------
module crossbar #(
   parameter int WIDTH          = 8,
   parameter int IN_PORTS       = 4,
   parameter int OUT_PORTS      = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int IN_ADDR_WIDTH  = 2,
   parameter int OUT_ADDR_WIDTH = 2,
   parameter int ROUTE_LSB      = 0,
   parameter int AF_MARGIN      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [0:IN_PORTS-1]           in_valid,
   input  logic [WIDTH*IN_PORTS-1:0]     in_data,
   output logic [0:IN_PORTS-1]           full,
   output logic [0:OUT_PORTS-1]          out_valid,
   output logic [WIDTH*OUT_PORTS-1:0]    out_data,
   input  logic [0:OUT_PORTS-1]          stall,
   output logic [0:IN_PORTS-1]           almost_full
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int ROUTES = 1 << OUT_ADDR_WIDTH;

   // A route value is legal only if it names an existing output.
   function automatic logic [ROUTES-1:0] route_ok_mask();
      logic [ROUTES-1:0] m;
      m = '0;
      for (int d = 0; d < ROUTES; d++) m[d] = (d < OUT_PORTS);
      return m;
   endfunction

   localparam logic [ROUTES-1:0] ROUTE_OK = route_ok_mask();

   // FIFO storage and state
   logic [WIDTH-1:0]          mem      [IN_PORTS][FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr   [IN_PORTS];
   logic [PTR_W-1:0]          rd_ptr   [IN_PORTS];
   logic [CNT_W-1:0]          count    [IN_PORTS];
   logic [CNT_W-1:0]          count_nxt[IN_PORTS];

   // Head-of-queue view
   logic [WIDTH-1:0]          head     [IN_PORTS];
   logic [OUT_ADDR_WIDTH-1:0] dest     [IN_PORTS];
   logic [IN_PORTS-1:0]       nonempty;
   logic [IN_PORTS-1:0]       bad_route;
   logic [IN_PORTS-1:0]       wr_en;
   logic [IN_PORTS-1:0]       pop;

   // Arbitration
   logic [IN_PORTS-1:0]       req      [OUT_PORTS];
   logic [OUT_PORTS-1:0]      grant_valid;
   logic [IN_ADDR_WIDTH-1:0]  grant_idx[OUT_PORTS];
   logic [IN_ADDR_WIDTH-1:0]  ptr_nxt  [OUT_PORTS];
   logic [IN_ADDR_WIDTH-1:0]  arb_ptr  [OUT_PORTS];

   // -------------------------------------------------------------------
   // Head decode and requests
   // -------------------------------------------------------------------
   // NOTE: every always_comb output gets a value on every path (defaults
   // first) so no latch is inferred.
   always_comb begin
      for (int i = 0; i < IN_PORTS; i++) begin
         head[i]      = mem[i][rd_ptr[i]];
         dest[i]      = head[i][ROUTE_LSB +: OUT_ADDR_WIDTH];
         nonempty[i]  = (count[i] != '0);
         bad_route[i] = nonempty[i] & ~ROUTE_OK[dest[i]];
         // Writes are judged against the registered flag, so a pop in the
         // same cycle does not rescue a write into a full FIFO.
         wr_en[i]     = in_valid[i] & ~full[i];
      end
      for (int o = 0; o < OUT_PORTS; o++) begin
         req[o] = '0;
         for (int i = 0; i < IN_PORTS; i++)
            req[o][i] = nonempty[i] & ~bad_route[i] &
                        (dest[i] == OUT_ADDR_WIDTH'(o));
      end
   end

   // -------------------------------------------------------------------
   // Per-output round-robin: first requester at or after arb_ptr wins.
   // -------------------------------------------------------------------
   always_comb begin
      int idx;
      idx = 0;
      for (int o = 0; o < OUT_PORTS; o++) begin
         grant_valid[o] = 1'b0;
         grant_idx[o]   = '0;
         ptr_nxt[o]     = arb_ptr[o];
         if (!stall[o]) begin
            for (int k = 0; k < IN_PORTS; k++) begin
               idx = (int'(arb_ptr[o]) + k) % IN_PORTS;
               if (!grant_valid[o] && req[o][idx]) begin
                  grant_valid[o] = 1'b1;
                  grant_idx[o]   = IN_ADDR_WIDTH'(idx);
                  ptr_nxt[o]     = IN_ADDR_WIDTH'((idx + 1) % IN_PORTS);
               end
            end
         end
      end
   end

   // An input targets one output only, so it can win at most one grant.
   // Bad-route heads are discarded without arbitration.
   always_comb begin
      pop = bad_route;
      for (int o = 0; o < OUT_PORTS; o++)
         if (grant_valid[o]) pop[grant_idx[o]] = 1'b1;
      for (int i = 0; i < IN_PORTS; i++)
         count_nxt[i] = count[i] + CNT_W'(wr_en[i]) - CNT_W'(pop[i]);
   end

   // -------------------------------------------------------------------
   // FIFO control state
   // -------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < IN_PORTS; i++) begin
            wr_ptr[i]      <= '0;
            rd_ptr[i]      <= '0;
            count[i]       <= '0;
            full[i]        <= 1'b0;
            almost_full[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < IN_PORTS; i++) begin
            if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
            count[i]       <= count_nxt[i];
            full[i]        <= (count_nxt[i] == CNT_W'(FIFO_DEPTH));
            almost_full[i] <= (count_nxt[i] >= CNT_W'(FIFO_DEPTH - AF_MARGIN));
         end
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by the
   // pointers and counts, so stale contents are never observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_PORTS; i++)
         if (wr_en[i])
            mem[i][wr_ptr[i]] <= in_data[(IN_PORTS-1-i)*WIDTH +: WIDTH];
   end

   // -------------------------------------------------------------------
   // Output register and arbiter pointers
   // -------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= '0;
         out_data  <= '0;
         for (int o = 0; o < OUT_PORTS; o++) arb_ptr[o] <= '0;
      end else begin
         for (int o = 0; o < OUT_PORTS; o++) begin
            out_valid[o] <= grant_valid[o];
            arb_ptr[o]   <= ptr_nxt[o];
            if (grant_valid[o])
               out_data[(OUT_PORTS-1-o)*WIDTH +: WIDTH] <= head[grant_idx[o]];
         end
      end
   end

`ifdef CROSSBAR_OVERFLOW_CHECK_EN
   // Simulation-only diagnostics; the datapath does not depend on them.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < IN_PORTS; i++) begin
            if (in_valid[i] && full[i])
               $display("%t crossbar %m: overflow input %0d", $time, i);
            if (bad_route[i])
               $display("%t crossbar %m: bad route input %0d", $time, i);
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_crossbar.sv
// ---------------------------------------------------------------------------
// tb_crossbar
//
// Self-checking bench for crossbar at default parameters. A queue-based
// model (one queue per input, one round-robin pointer per output) predicts
// out_valid/out_data/full/almost_full for every cycle; directed scenarios
// are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_crossbar;

   localparam int W   = 8;
   localparam int NI  = 4;
   localparam int NO  = 4;
   localparam int DEP = 8;
   localparam int AFM = 2;

   typedef logic [W-1:0] word_t;

   logic              clk;
   logic              rst;
   logic [0:NI-1]     in_valid;
   logic [W*NI-1:0]   in_data;
   logic [0:NI-1]     full;
   logic [0:NO-1]     out_valid;
   logic [W*NO-1:0]   out_data;
   logic [0:NO-1]     stall;
   logic [0:NI-1]     almost_full;

   crossbar dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .full        (full),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .stall       (stall),
      .almost_full (almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   word_t q [NI][$];
   int    rr [NO];
   logic  exp_valid [NO];
   word_t exp_data  [NO];
   logic  exp_full  [NI];
   logic  exp_af    [NI];

   int tests = 0;
   int fails = 0;
   int out3_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         q[i].delete();
         exp_full[i] = 1'b0;
         exp_af[i]   = 1'b0;
      end
      for (int o = 0; o < NO; o++) begin
         rr[o]        = 0;
         exp_valid[o] = 1'b0;
         exp_data[o]  = '0;
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      bit popped [NI];
      bit was_full;
      for (int i = 0; i < NI; i++) popped[i] = 1'b0;
      for (int o = 0; o < NO; o++) begin
         exp_valid[o] = 1'b0;
         if (!stall[o]) begin
            for (int k = 0; k < NI; k++) begin
               int i;
               i = (rr[o] + k) % NI;
               if (!exp_valid[o] && q[i].size() > 0 && (int'(q[i][0]) % NO) == o) begin
                  exp_valid[o] = 1'b1;
                  exp_data[o]  = q[i][0];
                  popped[i]    = 1'b1;
                  rr[o]        = (i + 1) % NI;
               end
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         was_full = (q[i].size() == DEP);
         if (popped[i]) void'(q[i].pop_front());
         if (in_valid[i] && !was_full) q[i].push_back(in_data[(NI-1-i)*W +: W]);
         exp_full[i] = (q[i].size() == DEP);
         exp_af[i]   = (q[i].size() >= DEP - AFM);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      for (int o = 0; o < NO; o++) begin
         check($sformatf("out_valid[%0d]", o), 32'(out_valid[o]), 32'(exp_valid[o]));
         check($sformatf("out_data[%0d]", o), 32'(out_data[(NO-1-o)*W +: W]), 32'(exp_data[o]));
      end
      for (int i = 0; i < NI; i++) begin
         check($sformatf("full[%0d]", i), 32'(full[i]), 32'(exp_full[i]));
         check($sformatf("almost_full[%0d]", i), 32'(almost_full[i]), 32'(exp_af[i]));
      end
      if (out_valid[3]) out3_seen++;
   endtask

   task automatic put(input int i, input word_t w);
      in_valid[i] = 1'b1;
      in_data[(NI-1-i)*W +: W] = w;
   endtask

   task automatic idle();
      in_valid = '0;
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = '0;
      in_data  = '0;
      stall    = '0;
      model_reset();

      // 1. Reset state, then single word to output 2
      #1;
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset full", 32'(full), 32'h0);
      check("reset almost_full", 32'(almost_full), 32'h0);
      check("reset out_data", 32'(out_data), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      put(0, 8'h02);
      step();
      idle();
      step();
      check("t1 out_valid[2]", 32'(out_valid[2]), 32'h1);
      check("t1 out_data[2]", 32'(out_data[(NO-1-2)*W +: W]), 32'h02);
      step();

      // 2. Contention on output 1
      put(0, 8'h11);
      put(1, 8'h21);
      put(3, 8'h41);
      step();
      idle();
      for (int n = 0; n < 4; n++) step();

      // 3. Inputs 0 and 2 stream to output 0
      for (int n = 0; n < 8; n++) begin
         put(0, word_t'({6'(n), 2'b00}));
         put(2, word_t'({6'(n + 32), 2'b00}));
         step();
      end
      idle();
      for (int n = 0; n < 20; n++) step();

      // 4. Back-pressure on input 1 while output 3 stalls
      stall[3] = 1'b1;
      for (int n = 0; n < 9; n++) begin
         put(1, word_t'({6'(n + 1), 2'b11}));
         step();
         if (n == 5) check("t4 almost_full[1] at 6", 32'(almost_full[1]), 32'h1);
         if (n == 6) check("t4 full[1] at 7", 32'(full[1]), 32'h0);
         if (n == 7) check("t4 full[1] at 8", 32'(full[1]), 32'h1);
      end
      idle();
      step();
      stall[3]  = 1'b0;
      out3_seen = 0;
      for (int n = 0; n < 12; n++) step();
      check("t4 words out of 3", 32'(out3_seen), 32'd8);

      // 5. Parallel routes
      put(0, 8'h01);
      put(1, 8'h00);
      step();
      idle();
      step();
      check("t5 both outputs", 32'({out_valid[0], out_valid[1]}), 32'h3);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NI; i++) begin
            in_valid[i] = ($urandom_range(0, 99) < 45);
            in_data[(NI-1-i)*W +: W] = word_t'($urandom);
         end
         for (int o = 0; o < NO; o++) stall[o] = ($urandom_range(0, 99) < 20);
         step();
      end
      idle();
      stall = '0;
      for (int n = 0; n < 40; n++) step();

      // 6. Mid-flight reset
      stall = '1;
      for (int n = 0; n < 5; n++) begin
         put(2, word_t'(8'h10 + n));
         step();
      end
      idle();
      #2 rst = 1'b0;
      #1;
      check("t6 out_valid in reset", 32'(out_valid), 32'h0);
      check("t6 full in reset", 32'(full), 32'h0);
      check("t6 almost_full in reset", 32'(almost_full), 32'h0);
      model_reset();
      @(negedge clk);
      rst   = 1'b1;
      stall = '0;
      for (int n = 0; n < 5; n++) step();
      check("t6 no output after reset", 32'(out_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
